// File: rtl/control_mc_param.sv
// Multicycle RV32I main control FSM with stretched memory states, illegal-opcode trap,
// retire pulse and memory-busy flag. Define MEM_HANDSHAKE_EN to finish memory states on mem_ready.
module control_mc_param #(
    parameter int WAIT_CYCLES = 2,
    parameter int WAIT_W      = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    output logic       EscrevePCCond,
    output logic       EscrevePC,
    output logic       IouD,
    output logic       EscreveMem,
    output logic       LeMem,
    output logic       EscreveIR,
    output logic       Mem2Reg,
    output logic       OrigAULA,
    output logic       EscreveReg,
    output logic [1:0] OrigPC,
    output logic [1:0] ALUOp,
    output logic [1:0] OrigBULA,
    output logic [4:0] Estado,
    output logic       mem_busy,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [4:0] {
        FETCH     = 5'd0,
        DECODE    = 5'd1,
        MEM_ADDR  = 5'd2,
        MEM_READ  = 5'd3,
        MEM_WRITE = 5'd4,
        MEM_WB    = 5'd5,
        EXEC_R    = 5'd6,
        R_WB      = 5'd7,
        EXEC_I    = 5'd8,
        I_WB      = 5'd9,
        BRANCH    = 5'd10,
        JAL       = 5'd11,
        JALR      = 5'd12,
        LUI       = 5'd13,
        TRAP      = 5'd14
    } state_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              in_mem_state;
    logic              mem_done;

    // funct3 only selects the ALU function in the datapath, never the sequence.
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

    assign in_mem_state = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);

    // mem_done is gated by reset_n so no write strobe can fire while reset is held.
`ifdef MEM_HANDSHAKE_EN
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
    assign mem_done   = reset_n & mem_ready;
`else
    logic unused_ready;
    assign unused_ready = mem_ready;
    assign mem_done     = reset_n & (cnt_q == WAIT_MAX);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MEM_HANDSHAKE_EN
    assign cnt_d = '0;
`else
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (in_mem_state && (cnt_q != WAIT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`endif

    always_comb begin
        // NOTE: every output and the next state get a default first, so no path infers a latch.
        state_d       = state_q;
        EscrevePCCond = 1'b0;
        EscrevePC     = 1'b0;
        IouD          = 1'b0;
        EscreveMem    = 1'b0;
        LeMem         = 1'b0;
        EscreveIR     = 1'b0;
        Mem2Reg       = 1'b0;
        OrigAULA      = 1'b0;
        EscreveReg    = 1'b0;
        OrigPC        = 2'd0;
        ALUOp         = 2'b00;
        OrigBULA      = 2'd0;
        mem_busy      = 1'b0;
        instr_done    = 1'b0;
        illegal       = 1'b0;

        unique case (state_q)
            FETCH: begin
                LeMem    = 1'b1;
                OrigBULA = 2'd1;
                mem_busy = ~mem_done;
                if (mem_done) begin
                    EscrevePC = 1'b1;
                    EscreveIR = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                OrigBULA = 2'd2;
                case (opcode)
                    OPC_R:                state_d = EXEC_R;
                    OPC_IMM:              state_d = EXEC_I;
                    OPC_LOAD, OPC_STORE:  state_d = MEM_ADDR;
                    OPC_BRANCH:           state_d = BRANCH;
                    OPC_JAL:              state_d = JAL;
                    OPC_JALR:             state_d = JALR;
                    OPC_LUI:              state_d = LUI;
                    default:              state_d = TRAP;
                endcase
            end
            MEM_ADDR: begin
                OrigAULA = 1'b1;
                OrigBULA = 2'd2;
                state_d  = (opcode == OPC_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                LeMem    = 1'b1;
                IouD     = 1'b1;
                mem_busy = ~mem_done;
                if (mem_done) state_d = MEM_WB;
            end
            MEM_WRITE: begin
                EscreveMem = 1'b1;
                IouD       = 1'b1;
                mem_busy   = ~mem_done;
                if (mem_done) begin
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
            end
            MEM_WB: begin
                EscreveReg = 1'b1;
                Mem2Reg    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            EXEC_R: begin
                OrigAULA = 1'b1;
                ALUOp    = 2'b10;
                state_d  = R_WB;
            end
            EXEC_I: begin
                OrigAULA = 1'b1;
                OrigBULA = 2'd2;
                state_d  = I_WB;
            end
            R_WB, I_WB: begin
                EscreveReg = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                OrigAULA      = 1'b1;
                ALUOp         = 2'b01;
                EscrevePCCond = 1'b1;
                OrigPC        = 2'd1;
                instr_done    = 1'b1;
                state_d       = FETCH;
            end
            JAL: begin
                EscrevePC  = 1'b1;
                OrigPC     = 2'd1;
                EscreveReg = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JALR: begin
                OrigAULA   = 1'b1;
                OrigBULA   = 2'd2;
                EscrevePC  = 1'b1;
                EscreveReg = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            LUI: begin
                OrigAULA   = 1'b1;
                OrigBULA   = 2'd2;
                ALUOp      = 2'b11;
                EscreveReg = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Held in reset the datapath sees a quiet fetch: read strobe and PC+4 operand only.
        if (!reset_n) begin
            EscrevePCCond = 1'b0;
            EscrevePC     = 1'b0;
            IouD          = 1'b0;
            EscreveMem    = 1'b0;
            LeMem         = 1'b1;
            EscreveIR     = 1'b0;
            Mem2Reg       = 1'b0;
            OrigAULA      = 1'b0;
            EscreveReg    = 1'b0;
            OrigPC        = 2'd0;
            ALUOp         = 2'b00;
            OrigBULA      = 2'd1;
            mem_busy      = 1'b0;
            instr_done    = 1'b0;
            illegal       = 1'b0;
        end
    end

    assign Estado = state_q;

endmodule
